// File: rtl/bcd_digit_entry_pkg.sv
// Shared calculator package: digit-entry state encoding, BCD limits,
// the default operand width (also used by the BCD-to-binary converter),
// and the shift-register opcode used between the entry FSM and its datapath.
package bcd_digit_entry_pkg;

  localparam int         DIGITS_DEFAULT = 3;
  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;

  // Entry FSM state encoding
  localparam logic [0:0] ST_ENTRY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  typedef enum logic [1:0] {
    SR_HOLD = 2'd0,
    SR_SHL  = 2'd1,  // shift a new ones digit in
    SR_SHR  = 2'd2,  // drop the ones digit, zero-fill the top
    SR_CLR  = 2'd3
  } sr_op_e;

endpackage

// File: rtl/bcd_digit_entry_if.sv
// Keypad / converter bus for the digit-entry stage.
//   master : keypad scanner + downstream converter side (drives strobes, ack)
//   slave  : the entry stage (drives operand, sign, valid, count, error)
interface bcd_digit_entry_if
  import bcd_digit_entry_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic                  digitStrobe;
  logic [3:0]            digitIn;
  logic                  negStrobe;
  logic                  backStrobe;
  logic                  clearStrobe;
  logic                  enterStrobe;
  logic                  numberAck;
  logic [4*DIGITS-1:0]   numberOut;
  logic                  sign;
  logic                  numberValid;
  logic [CNT_W-1:0]      digitCount;
  logic                  entryError;

  modport master (
    output digitStrobe, digitIn, negStrobe, backStrobe, clearStrobe,
           enterStrobe, numberAck,
    input  numberOut, sign, numberValid, digitCount, entryError
  );

  modport slave (
    input  digitStrobe, digitIn, negStrobe, backStrobe, clearStrobe,
           enterStrobe, numberAck,
    output numberOut, sign, numberValid, digitCount, entryError
  );

endinterface

// File: rtl/bcd_shift_reg.sv
// DIGITS-nibble BCD shift register. Nibble 0 is the ones digit.
//   clk, rst_n : clock, async active-low reset
//   op         : hold / shift-left (din enters at ones) / shift-right / clear
//   din        : digit shifted in on SR_SHL
//   q          : register contents, q[DIGITS-1] is the most significant digit
module bcd_shift_reg
  import bcd_digit_entry_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  sr_op_e                 op,
  input  logic [3:0]             din,
  output logic [DIGITS-1:0][3:0] q
);

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_nib
      logic [3:0] lo, hi, r;

      if (i == 0) begin : g_lo_in
        assign lo = din;
      end else begin : g_lo_chain
        assign lo = q[i-1];
      end

      if (i == DIGITS - 1) begin : g_hi_zero
        assign hi = 4'h0;
      end else begin : g_hi_chain
        assign hi = q[i+1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r <= 4'h0;
        end else begin
          case (op)
            SR_SHL:  r <= lo;
            SR_SHR:  r <= hi;
            SR_CLR:  r <= 4'h0;
            default: r <= r;
          endcase
        end
      end

      assign q[i] = r;
    end
  endgenerate

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad operand entry stage. Accumulates a signed DIGITS-digit BCD magnitude
// from one-cycle keypad events (priority clear > enter > back > negate > digit)
// and holds it with numberValid until the converter acks it.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of bcd_digit_entry_if (strobes/ack in; operand,
//                sign, valid, digit count and error pulse out, all registered)
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_digit_entry_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  logic [0:0]             state, state_nx;
  logic                   sign_q, sign_nx;
  logic                   err_q, err_nx;
  logic [CNT_W-1:0]       cnt_q, cnt_nx;
  sr_op_e                 sr_op;
  logic [DIGITS-1:0][3:0] mag;

  bcd_shift_reg #(.DIGITS(DIGITS)) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (sr_op),
    .din   (bus.digitIn),
    .q     (mag)
  );

  always_comb begin
    sr_op    = SR_HOLD;
    state_nx = state;
    sign_nx  = sign_q;
    cnt_nx   = cnt_q;
    err_nx   = 1'b0;
    if (bus.clearStrobe) begin
      // Clear also pre-empts a same-cycle ack, without raising an error.
      sr_op    = SR_CLR;
      state_nx = ST_ENTRY;
      sign_nx  = 1'b0;
      cnt_nx   = '0;
    end else if (state == ST_HOLD) begin
      // Operand is frozen: every keypad edit is rejected.
      err_nx = bus.enterStrobe | bus.backStrobe | bus.negStrobe | bus.digitStrobe;
      if (bus.numberAck) begin
        sr_op    = SR_CLR;
        state_nx = ST_ENTRY;
        sign_nx  = 1'b0;
        cnt_nx   = '0;
      end
    end else if (bus.enterStrobe) begin
      state_nx = ST_HOLD;
    end else if (bus.backStrobe) begin
      if (cnt_q == '0) begin
        err_nx = 1'b1;
      end else begin
        sr_op  = SR_SHR;
        cnt_nx = cnt_q - CNT_ONE;
        // Deleting the last digit leaves zero, which is never negative.
        if (cnt_q == CNT_ONE) sign_nx = 1'b0;
      end
    end else if (bus.negStrobe) begin
      if (cnt_q == '0) err_nx = 1'b1;
      else             sign_nx = ~sign_q;
    end else if (bus.digitStrobe) begin
      if (bus.digitIn > BCD_DIGIT_MAX || cnt_q == CNT_FULL) begin
        err_nx = 1'b1;
      end else if (bus.digitIn != 4'h0 || cnt_q != '0) begin
        // A leading zero is accepted but leaves value and count untouched.
        sr_op  = SR_SHL;
        cnt_nx = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_ENTRY;
      sign_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      sign_q <= sign_nx;
      cnt_q  <= cnt_nx;
      err_q  <= err_nx;
    end
  end

  assign bus.numberOut   = mag;
  assign bus.sign        = sign_q;
  assign bus.numberValid = (state == ST_HOLD);
  assign bus.digitCount  = cnt_q;
  assign bus.entryError  = err_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed scenarios plus randomized keypad
// traffic, compared every cycle against an integer-magnitude model.
module tb_bcd_digit_entry;

  logic clk = 1'b0;
  logic rst_n;

  bcd_digit_entry_if #(.DIGITS(3)) bus ();

  bcd_digit_entry #(.DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: operand kept as a plain decimal integer 0..999.
  int m_mag;
  bit m_neg;
  bit m_hold;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int m);
    return 32'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  function automatic logic [31:0] ndig(input int m);
    if (m == 0)  return 0;
    if (m < 10)  return 1;
    if (m < 100) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_mag = 0; m_neg = 0; m_hold = 0; m_err = 0;
  endtask

  task automatic model_step(input bit d, input int din, input bit n, input bit b,
                            input bit c, input bit e, input bit a);
    m_err = 0;
    if (c) begin
      m_mag = 0; m_neg = 0; m_hold = 0;
    end else if (m_hold) begin
      if (e || b || n || d) m_err = 1;
      if (a) begin m_mag = 0; m_neg = 0; m_hold = 0; end
    end else if (e) begin
      m_hold = 1;
    end else if (b) begin
      if (m_mag == 0) m_err = 1;
      else begin
        m_mag = m_mag / 10;
        if (m_mag == 0) m_neg = 0;
      end
    end else if (n) begin
      if (m_mag == 0) m_err = 1;
      else m_neg = !m_neg;
    end else if (d) begin
      if (din > 9 || m_mag >= 100) m_err = 1;
      else m_mag = m_mag * 10 + din;
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".num"},   32'(bus.numberOut),   to_bcd(m_mag));
    chk({t, ".sign"},  32'(bus.sign),        32'(m_neg));
    chk({t, ".valid"}, 32'(bus.numberValid), 32'(m_hold));
    chk({t, ".cnt"},   32'(bus.digitCount),  ndig(m_mag));
    chk({t, ".err"},   32'(bus.entryError),  32'(m_err));
  endtask

  task automatic idle_inputs();
    bus.digitStrobe = 0; bus.digitIn = 0; bus.negStrobe = 0; bus.backStrobe = 0;
    bus.clearStrobe = 0; bus.enterStrobe = 0; bus.numberAck = 0;
  endtask

  task automatic step(input string t, input bit d, input int din, input bit n,
                      input bit b, input bit c, input bit e, input bit a);
    bus.digitStrobe = d; bus.digitIn = 4'(din); bus.negStrobe = n;
    bus.backStrobe = b; bus.clearStrobe = c; bus.enterStrobe = e; bus.numberAck = a;
    @(posedge clk);
    model_step(d, din, n, b, c, e, a);
    #1;
    idle_inputs();
    check_all(t);
  endtask

  task automatic key(input string t, input int din);
    step(t, 1, din, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst.num",   32'(bus.numberOut),   0);
    chk("rst.valid", 32'(bus.numberValid), 0);
    chk("rst.cnt",   32'(bus.digitCount),  0);
    chk("rst.err",   32'(bus.entryError),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1,2,3 enter, ack
    key("t1.d1", 1); key("t1.d2", 2); key("t1.d3", 3);
    step("t1.ent", 0, 0, 0, 0, 0, 1, 0);
    chk("t1.val123", 32'(bus.numberOut), 32'h123);
    chk("t1.vld",    32'(bus.numberValid), 1);
    step("t1.ack", 0, 0, 0, 0, 0, 0, 1);
    chk("t1.vld_lo", 32'(bus.numberValid), 0);

    // 4,5, negate, back, back
    key("t2.d4", 4); key("t2.d5", 5);
    step("t2.neg", 0, 0, 1, 0, 0, 0, 0);
    chk("t2.neg_val", 32'(bus.numberOut), 32'h045);
    chk("t2.neg_sgn", 32'(bus.sign), 1);
    step("t2.bk1", 0, 0, 0, 1, 0, 0, 0);
    chk("t2.bk1_val", 32'(bus.numberOut), 32'h004);
    step("t2.bk2", 0, 0, 0, 1, 0, 0, 0);
    chk("t2.bk2_sgn", 32'(bus.sign), 0);

    // errors: overflow, invalid code, negate at zero
    key("t3.d9a", 9); key("t3.d9b", 9); key("t3.d9c", 9);
    key("t3.ovf", 7);
    chk("t3.ovf_err", 32'(bus.entryError), 1);
    chk("t3.ovf_val", 32'(bus.numberOut), 32'h999);
    step("t3.clr", 0, 0, 0, 0, 1, 0, 0);
    key("t3.badC", 12);
    chk("t3.badC_err", 32'(bus.entryError), 1);
    step("t3.neg0", 0, 0, 1, 0, 0, 0, 0);
    chk("t3.neg0_err", 32'(bus.entryError), 1);

    // leading zeros
    key("t4.z1", 0); key("t4.z2", 0); key("t4.d8", 8);
    step("t4.ent", 0, 0, 0, 0, 0, 1, 0);
    chk("t4.val", 32'(bus.numberOut), 32'h008);
    chk("t4.cnt", 32'(bus.digitCount), 1);
    step("t4.ack", 0, 0, 0, 0, 0, 0, 1);

    // priority
    key("t5.d5", 5); key("t5.d6", 6);
    step("t5.clr_ent", 0, 0, 0, 0, 1, 1, 0);
    chk("t5.clr_vld", 32'(bus.numberValid), 0);
    key("t5.d5b", 5); key("t5.d6b", 6);
    step("t5.ent_dig", 1, 7, 0, 0, 0, 1, 0);
    chk("t5.hold_val", 32'(bus.numberOut), 32'h056);

    // HOLD abort cases
    key("t6.hold_dig", 3);
    chk("t6.hold_err", 32'(bus.entryError), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.arst_vld", 32'(bus.numberValid), 0);
    chk("t6.arst_num", 32'(bus.numberOut), 0);
    #1 rst_n = 1'b1;
    key("t7.d1", 1);
    step("t7.ent", 0, 0, 0, 0, 0, 1, 0);
    step("t7.clr_ack", 0, 0, 0, 0, 1, 0, 1);
    chk("t7.err", 32'(bus.entryError), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int din;
      din = ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      step("rnd", ($urandom % 3 == 0), din, ($urandom % 8 == 0), ($urandom % 6 == 0),
           ($urandom % 25 == 0), ($urandom % 10 == 0), ($urandom % 4 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_digit_entry.md
# bcd_digit_entry

Keypad-side operand entry stage for the calculator datapath. Accepts one-cycle digit, sign, backspace, clear and enter events from the keypad scanner. Accumulates a signed 3-digit BCD magnitude, left-shifting digits in as typed. On enter, presents `numberOut`/`sign` with a valid/ack handshake directly to the BCD-to-binary converter feeding the ALU.

## Interface
- `DIGITS`, default 3: BCD digits held; magnitude width is 4*DIGITS (12 by default).
- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `digitStrobe` input 1: one-cycle pulse, `digitIn` is a new keypress.
- `digitIn` input 4: BCD digit 0-9; codes 10-15 are invalid.
- `negStrobe` input 1: one-cycle pulse, toggle sign.
- `backStrobe` input 1: one-cycle pulse, delete the least significant digit.
- `clearStrobe` input 1: one-cycle pulse, clear entry and abort any pending handshake.
- `enterStrobe` input 1: one-cycle pulse, commit the operand.
- `numberAck` input 1: downstream has taken the operand.
- `numberOut` output 4*DIGITS: BCD magnitude, hundreds in [11:8], ones in [3:0].
- `sign` output 1: 1 = negative.
- `numberValid` output 1: operand committed and held stable.
- `digitCount` output 2: significant digits entered, 0..DIGITS.
- `entryError` output 1: one-cycle pulse on a rejected keypress.

## Operation
- FSM states are ENTRY and HOLD. Reset enters ENTRY with all outputs 0.
- Events are resolved per cycle by priority: clear > enter > backspace > negate > digit. Only the highest-priority asserted event acts; lower-priority events in the same cycle are dropped silently (no error).
- Digit in ENTRY:
  - `digitIn` > 9: rejected, `entryError`.
  - `digitCount` == DIGITS: rejected, `entryError`, value unchanged.
  - `digitIn` == 0 with `digitCount` == 0: accepted; value stays 0, count stays 0 (leading zero suppressed).
  - Otherwise `numberOut` <= {numberOut[4*DIGITS-5:0], digitIn} and `digitCount`++.
- Backspace in ENTRY:
  - `digitCount` == 0: `entryError`.
  - Otherwise `numberOut` <= {4'h0, numberOut[4*DIGITS-1:4]} and `digitCount`--.
  - When the count reaches 0, `sign` is cleared.
- Negate in ENTRY:
  - `digitCount` == 0: ignored with `entryError`. Negative zero is never produced.
  - Otherwise `sign` <= ~`sign`.
- Enter in ENTRY: transition to HOLD with `numberValid` = 1. Enter with count 0 commits +0.
- Clear, any state: `numberOut`, `sign`, `digitCount` and `numberValid` all go to 0; state becomes ENTRY.
- HOLD:
  - `numberOut` and `sign` are frozen.
  - Digit, backspace, negate and enter each produce `entryError` and no other effect.
  - `numberAck` with `numberValid` high: next cycle `numberValid` = 0, value/sign/count are cleared, state becomes ENTRY.
  - Clear beats ack in the same cycle. The result is the same, and no error is raised.
- `numberAck` in ENTRY is ignored.

## Timing
- All outputs are registered.
- Each event is visible on the outputs one cycle after its strobe edge.
- `entryError` is high for exactly one cycle, the cycle after the offending strobe.
- Enter to `numberValid`: 1 cycle. The earliest ack is the cycle `numberValid` is first seen high.
- Ack to `numberValid` low: 1 cycle. A new digit is accepted on the cycle `numberValid` drops.
- Back-to-back strobes on consecutive cycles are each processed; no event is lost unless pre-empted by priority.
- Reset mid-HOLD drops `numberValid` asynchronously. Downstream must treat this as a withdrawn operand.

## Structure
- Shared calculator package holds:
  - the state encoding (ENTRY=0, HOLD=1);
  - `BCD_DIGIT_MAX` = 9;
  - the default digit count of 3, shared with the converter stage.
- Natural sub-module: `bcd_shift_reg`, holding the DIGITS-nibble left/right shift register with load-zero. The FSM, priority logic and counter stay in the top.
- No combinational paths from inputs to outputs.

## Test plan
- Digit strobes 1,2,3 then enter:
  - `numberOut` = 12'h123, `sign` 0, `digitCount` 3.
  - `numberValid` 1 cycle after enter; ack clears to 0 next cycle.
- Digits 4,5, negate, backspace, backspace:
  - after the negate, 12'h045 with `sign` 1;
  - after the first backspace, 12'h004 with `sign` 1;
  - after the second backspace, 0 with `sign` 0.
- Error cases:
  - digits 9,9,9 then a fourth digit 7: `entryError` pulse, value stays 12'h999;
  - `digitIn` = 4'hC: `entryError` pulse;
  - negate at count 0: `entryError` pulse.
- Digits 0,0,8 then enter: `numberOut` 12'h008 and `digitCount` 1.
- Priority: clear and enter in the same cycle after 12'h056, expect 0 and `numberValid` stays 0. Enter and digit in the same cycle: HOLD with the prior value and the digit dropped.
- Mid-operation aborts:
  - in HOLD, digit 3: `entryError` and value unchanged;
  - assert `rst_n` low asynchronously mid-HOLD: all outputs 0 immediately;
  - clear and ack together: ENTRY and no error.
